// File: rtl/nx_token_arbiter_if.sv
// Handshake bundle between nx_control/nx_mesh and the token arbiter.
// The master drives enable/request/release; the slave (arbiter) drives grant and status.
interface nx_token_arbiter_if #(
    parameter int COLUMNS = 3,
    parameter int CNT_W   = 16
);
    localparam int OW = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;

    logic               enable_i;
    logic [COLUMNS-1:0] token_request_i;
    logic [COLUMNS-1:0] token_release_i;
    logic [COLUMNS-1:0] token_grant_o;
    logic [OW-1:0]      owner_o;
    logic               busy_o;
    logic               timeout_o;
    logic [CNT_W-1:0]   grant_count_o;

    modport master (
        output enable_i, token_request_i, token_release_i,
        input  token_grant_o, owner_o, busy_o, timeout_o, grant_count_o
    );

    modport slave (
        input  enable_i, token_request_i, token_release_i,
        output token_grant_o, owner_o, busy_o, timeout_o, grant_count_o
    );
endinterface

// File: rtl/nx_token_arbiter.sv
// Round-robin arbiter for the single nx_mesh token, with a one-cycle gap
// between owners and an optional hold-timeout that revokes a stuck owner.
module nx_token_arbiter #(
    parameter int COLUMNS  = 3,
    parameter int MAX_HOLD = 256,
    parameter int CNT_W    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    nx_token_arbiter_if.slave    bus
);
    localparam int OW = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [OW-1:0] LAST_COL  = OW'(COLUMNS - 1);

    typedef enum logic [1:0] {IDLE, HELD, GAP} state_t;

    state_t             state_q, state_d;
    logic [COLUMNS-1:0] grant_q, grant_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic [OW-1:0]      ptr_q, ptr_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               busy_q, busy_d;
    logic               timeout_q, timeout_d;

    logic               found;
    logic [OW-1:0]      win;
    logic [OW-1:0]      cand;

    function automatic logic [OW-1:0] next_col(input logic [OW-1:0] c);
        return (c == LAST_COL) ? '0 : c + 1'b1;
    endfunction

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        count_d   = count_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;

        // Scan from the pointer upward, wrapping, for the first requester.
        found = 1'b0;
        win   = '0;
        cand  = ptr_q;
        for (int i = 0; i < COLUMNS; i++) begin
            if (!found && bus.token_request_i[cand]) begin
                found = 1'b1;
                win   = cand;
            end
            cand = next_col(cand);
        end

        case (state_q)
            IDLE, GAP: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                if (bus.enable_i && found) begin
                    state_d = HELD;
                    grant_d = COLUMNS'(1) << win;
                    owner_d = win;
                    busy_d  = 1'b1;
                    hold_d  = '0;
                    count_d = count_q + 1'b1;
                end
            end
            HELD: begin
                if (bus.token_release_i[owner_q]) begin
                    state_d = GAP;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    ptr_d   = next_col(owner_q);
                end else if (MAX_HOLD != 0 && hold_q == HOLD_LAST) begin
                    state_d   = GAP;
                    grant_d   = '0;
                    busy_d    = 1'b0;
                    ptr_d     = next_col(owner_q);
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.token_grant_o = grant_q;
    assign bus.owner_o       = owner_q;
    assign bus.busy_o        = busy_q;
    assign bus.timeout_o     = timeout_q;
    assign bus.grant_count_o = count_q;
endmodule

// File: tb/tb_nx_token_arbiter.sv
// Directed bench for nx_token_arbiter: 3 columns, 4-cycle hold limit and a
// 3-bit grant counter so the counter wrap is reached in a short run.
module tb_nx_token_arbiter;
    logic clk;
    logic rst_n;
    int   passed;
    int   total;
    int   order [4] = '{0, 1, 2, 0};
    logic [2:0] oh;

    nx_token_arbiter_if #(.COLUMNS(3), .CNT_W(3)) bus ();

    nx_token_arbiter #(.COLUMNS(3), .MAX_HOLD(4), .CNT_W(3)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n  = 1'b0;
        bus.enable_i        = 1'b0;
        bus.token_request_i = 3'b000;
        bus.token_release_i = 3'b000;
        tick();
        tick();
        chk("rst_grant",   bus.token_grant_o, 3'b000);
        chk("rst_busy",    bus.busy_o, 1'b0);
        chk("rst_owner",   bus.owner_o, 0);
        chk("rst_timeout", bus.timeout_o, 1'b0);
        chk("rst_count",   bus.grant_count_o, 0);
        rst_n = 1'b1;

        // Single request from column 1
        bus.enable_i        = 1'b1;
        bus.token_request_i = 3'b010;
        tick();
        chk("single_grant", bus.token_grant_o, 3'b010);
        chk("single_owner", bus.owner_o, 1);
        chk("single_busy",  bus.busy_o, 1'b1);
        chk("single_count", bus.grant_count_o, 1);
        bus.token_request_i = 3'b000;
        tick();
        chk("withdraw_keeps_grant", bus.token_grant_o, 3'b010);
        bus.token_release_i = 3'b010;
        tick();
        bus.token_release_i = 3'b000;
        chk("single_rel_grant",   bus.token_grant_o, 3'b000);
        chk("single_rel_busy",    bus.busy_o, 1'b0);
        chk("single_rel_timeout", bus.timeout_o, 1'b0);
        chk("owner_holds",        bus.owner_o, 1);
        chk("single_rel_count",   bus.grant_count_o, 1);
        tick();

        // Reset so round-robin starts with the pointer at column 0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst2_count", bus.grant_count_o, 0);

        bus.token_request_i = 3'b111;
        for (int k = 0; k < 4; k++) begin
            oh = 3'(1) << order[k];
            tick();
            chk("rr_grant",  bus.token_grant_o, oh);
            chk("rr_owner",  bus.owner_o, order[k]);
            tick();
            chk("rr_hold",   bus.token_grant_o, oh);
            bus.token_release_i = oh;
            tick();
            bus.token_release_i = 3'b000;
            chk("rr_gap",    bus.token_grant_o, 3'b000);
            chk("rr_gap_to", bus.timeout_o, 1'b0);
        end
        chk("rr_count", bus.grant_count_o, 4);
        bus.token_request_i = 3'b000;
        tick();

        // Timeout: column 2 never releases (pointer now 1)
        bus.token_request_i = 3'b100;
        tick();
        chk("to_grant", bus.token_grant_o, 3'b100);
        chk("to_owner", bus.owner_o, 2);
        chk("to_count", bus.grant_count_o, 5);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("to_still_held", bus.token_grant_o, 3'b100);
            chk("to_no_pulse",   bus.timeout_o, 1'b0);
        end
        bus.token_request_i = 3'b101;
        tick();
        chk("to_drop",  bus.token_grant_o, 3'b000);
        chk("to_pulse", bus.timeout_o, 1'b1);
        chk("to_busy",  bus.busy_o, 1'b0);
        tick();
        chk("to_next_grant", bus.token_grant_o, 3'b001);
        chk("to_pulse_once", bus.timeout_o, 1'b0);
        chk("to_next_count", bus.grant_count_o, 6);
        bus.token_release_i = 3'b001;
        tick();
        bus.token_release_i = 3'b000;
        chk("to_rel0", bus.token_grant_o, 3'b000);

        // Release on the same edge as the timeout: counts as a release
        tick();
        chk("rt_grant", bus.token_grant_o, 3'b100);
        chk("rt_count", bus.grant_count_o, 7);
        tick();
        tick();
        tick();
        chk("rt_held", bus.token_grant_o, 3'b100);
        bus.token_release_i = 3'b100;
        tick();
        bus.token_release_i = 3'b000;
        chk("rt_drop",    bus.token_grant_o, 3'b000);
        chk("rt_no_tout", bus.timeout_o, 1'b0);

        // Spurious release from non-owners; eighth grant wraps the counter
        tick();
        chk("sp_grant", bus.token_grant_o, 3'b001);
        chk("cnt_wrap", bus.grant_count_o, 0);
        bus.token_release_i = 3'b110;
        tick();
        chk("sp_grant_kept", bus.token_grant_o, 3'b001);
        chk("sp_no_tout",    bus.timeout_o, 1'b0);
        bus.token_release_i = 3'b001;
        tick();
        bus.token_release_i = 3'b000;
        bus.token_request_i = 3'b000;
        chk("sp_rel", bus.token_grant_o, 3'b000);
        tick();

        // Enable gating
        bus.enable_i        = 1'b0;
        bus.token_request_i = 3'b001;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("en_blocked", bus.token_grant_o, 3'b000);
        end
        bus.enable_i = 1'b1;
        tick();
        chk("en_grant", bus.token_grant_o, 3'b001);
        chk("en_count", bus.grant_count_o, 1);
        bus.enable_i = 1'b0;
        tick();
        chk("en_drop_keeps", bus.token_grant_o, 3'b001);
        chk("en_drop_busy",  bus.busy_o, 1'b1);
        bus.enable_i        = 1'b1;
        bus.token_release_i = 3'b001;
        tick();
        bus.token_release_i = 3'b000;
        bus.token_request_i = 3'b100;
        tick();
        chk("mr_owner", bus.owner_o, 2);

        // Reset while column 2 holds the token
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mr_grant",   bus.token_grant_o, 3'b000);
        chk("mr_busy",    bus.busy_o, 1'b0);
        chk("mr_timeout", bus.timeout_o, 1'b0);
        chk("mr_owner0",  bus.owner_o, 0);
        chk("mr_count",   bus.grant_count_o, 0);
        bus.token_request_i = 3'b101;
        tick();
        chk("mr_after_grant", bus.token_grant_o, 3'b001);
        chk("mr_after_owner", bus.owner_o, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
